// File: rtl/bip_loader_if.sv
// Signal bundle between the BIP loader, the UART byte stream and the BIP top.
// master = loader side; slave = the UART/BIP environment it drives.
interface bip_loader_if #(
  parameter int DATA_LENGTH = 16,
  parameter int ADDR_LENGTH = 11
);
  logic [7:0]             rx_data;
  logic                   rx_valid;
  logic [7:0]             tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic                   WrPM;
  logic                   WrDM;
  logic                   RdDM;
  logic [ADDR_LENGTH-1:0] addrFromInterface;
  logic [DATA_LENGTH-1:0] dataFromInterface;
  logic [DATA_LENGTH-1:0] data_from_dm;
  logic                   reset_bip;
  logic                   busy;
  logic                   cmd_err;

  modport master (
    input  rx_data, rx_valid, tx_ready, data_from_dm,
    output tx_data, tx_valid, WrPM, WrDM, RdDM, addrFromInterface,
           dataFromInterface, reset_bip, busy, cmd_err
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, data_from_dm,
    input  tx_data, tx_valid, WrPM, WrDM, RdDM, addrFromInterface,
           dataFromInterface, reset_bip, busy, cmd_err
  );
endinterface

// File: rtl/bip_loader.sv
// BIP memory-load/debug initiator: parses UART command bytes into PM/DM write and
// DM read strobes, returns read data as two tx bytes, and gates the CPU reset.
module bip_loader #(
  parameter int DATA_LENGTH    = 16,
  parameter int ADDR_LENGTH    = 11,
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic          clk,
  input logic          reset,
  bip_loader_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE, ADDR_H, ADDR_L, DATA_H, DATA_L, WRITE, READ, WAIT, SEND_H, SEND_L
  } state_t;

  state_t                 state, state_nx;
  logic [1:0]             op;
  logic                   ignore;
  logic [ADDR_LENGTH-9:0] addr_hi;
  logic [7:0]             data_hi;
  logic [ADDR_LENGTH-1:0] addr;
  logic [DATA_LENGTH-1:0] data;
  logic [DATA_LENGTH-1:0] rd_data;
  logic [TW-1:0]          idle_cnt;
  logic [2:0]             wait_cnt;
  logic                   reset_bip;
  logic                   cmd_err;
  logic                   byte_state;
  logic                   timeout;
  logic                   wait_done;
  logic                   wr_pm, wr_dm, rd_dm, tx_valid, busy;
  logic [7:0]             tx_data;

  assign byte_state = state inside {ADDR_H, ADDR_L, DATA_H, DATA_L};
  assign timeout    = byte_state && !bus.rx_valid && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign wait_done  = (wait_cnt == 3'(READ_LATENCY - 1));

  // NOTE: every variable assigned in this block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.rx_valid && bus.rx_data inside {8'h01, 8'h02, 8'h03}) state_nx = ADDR_H;
      ADDR_H:  if (bus.rx_valid) state_nx = ADDR_L;
      ADDR_L:  if (bus.rx_valid) begin
                 if (op != 2'd3)  state_nx = DATA_H;
                 else if (ignore) state_nx = IDLE;
                 else             state_nx = READ;
               end
      DATA_H:  if (bus.rx_valid) state_nx = DATA_L;
      DATA_L:  if (bus.rx_valid) state_nx = ignore ? IDLE : WRITE;
      WRITE:   state_nx = IDLE;
      READ:    state_nx = WAIT;
      WAIT:    if (wait_done) state_nx = SEND_H;
      SEND_H:  if (bus.tx_ready) state_nx = SEND_L;
      SEND_L:  if (bus.tx_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (timeout) state_nx = IDLE;
  end

  always_comb begin
    wr_pm    = 1'b0;
    wr_dm    = 1'b0;
    rd_dm    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = (state != IDLE);
    case (state)
      WRITE:   begin
                 wr_pm = (op == 2'd1);
                 wr_dm = (op == 2'd2);
               end
      READ:    rd_dm = 1'b1;
      SEND_H:  begin
                 tx_valid = 1'b1;
                 tx_data  = rd_data[15:8];
               end
      SEND_L:  begin
                 tx_valid = 1'b1;
                 tx_data  = rd_data[7:0];
               end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      op        <= '0;
      ignore    <= 1'b0;
      addr_hi   <= '0;
      data_hi   <= '0;
      addr      <= '0;
      data      <= '0;
      rd_data   <= '0;
      idle_cnt  <= '0;
      wait_cnt  <= '0;
      reset_bip <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      state <= state_nx;

      if (bus.rx_valid || !byte_state) idle_cnt <= '0;
      else                             idle_cnt <= idle_cnt + 1'b1;

      case (state)
        IDLE: if (bus.rx_valid) begin
          case (bus.rx_data)
            8'h01, 8'h02, 8'h03: begin
              op     <= bus.rx_data[1:0];
              // Loading while the CPU runs is consumed byte-for-byte but never reaches memory.
              ignore <= reset_bip;
              if (reset_bip) cmd_err <= 1'b1;
            end
            8'h04:   reset_bip <= 1'b1;
            8'h05:   reset_bip <= 1'b0;
            default: cmd_err   <= 1'b1;
          endcase
        end
        ADDR_H: if (bus.rx_valid) addr_hi <= bus.rx_data[ADDR_LENGTH-9:0];
        ADDR_L: if (bus.rx_valid && !ignore) addr <= {addr_hi, bus.rx_data};
        DATA_H: if (bus.rx_valid) data_hi <= bus.rx_data;
        DATA_L: if (bus.rx_valid && !ignore) data <= {data_hi, bus.rx_data};
        READ:   wait_cnt <= '0;
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_done) rd_data <= bus.data_from_dm;
        end
        default: ;
      endcase

      // Bytes arriving while a strobe or read transfer is in flight are dropped and flagged.
      if (bus.rx_valid && state inside {WRITE, READ, WAIT, SEND_H, SEND_L}) cmd_err <= 1'b1;
      if (timeout) cmd_err <= 1'b1;
    end
  end

  assign bus.WrPM              = wr_pm;
  assign bus.WrDM              = wr_dm;
  assign bus.RdDM              = rd_dm;
  assign bus.tx_valid          = tx_valid;
  assign bus.tx_data           = tx_data;
  assign bus.busy              = busy;
  assign bus.addrFromInterface = addr;
  assign bus.dataFromInterface = data;
  assign bus.reset_bip         = reset_bip;
  assign bus.cmd_err           = cmd_err;

endmodule

// File: tb/tb_bip_loader.sv
// Scoreboard bench for bip_loader: expected strobes and tx bytes are queued as commands
// are sent and compared by a negedge monitor; a small DM model answers reads.
module tb_bip_loader;

  localparam int RL = 2;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bip_loader_if bus ();

  bip_loader #(
    .DATA_LENGTH(16), .ADDR_LENGTH(11), .READ_LATENCY(RL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef enum logic [1:0] {K_PM, K_DM, K_RD} kind_t;
  typedef struct {
    kind_t       kind;
    logic [10:0] addr;
    logic [15:0] data;
  } strobe_t;

  strobe_t    exp_q[$];
  logic [7:0] tx_q[$];
  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  // Data memory model with READ_LATENCY pipeline
  logic [15:0] dm_mem [0:2047];
  logic [7:0]  rd_pipe = '0;
  logic [10:0] rd_addr_pipe [0:7];
  always @(posedge clk) begin
    rd_pipe <= {rd_pipe[6:0], bus.RdDM};
    rd_addr_pipe[0] <= bus.addrFromInterface;
    for (int i = 1; i < 8; i++) rd_addr_pipe[i] <= rd_addr_pipe[i-1];
    if (bus.WrDM) dm_mem[bus.addrFromInterface] <= bus.dataFromInterface;
  end
  assign bus.data_from_dm = rd_pipe[RL-1] ? dm_mem[rd_addr_pipe[RL-1]] : 16'h0000;

  // Monitor: strobes and tx bytes against the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.WrPM || bus.WrDM || bus.RdDM) begin
        automatic kind_t k = bus.WrPM ? K_PM : (bus.WrDM ? K_DM : K_RD);
        checks++;
        if ((32'(bus.WrPM) + 32'(bus.WrDM) + 32'(bus.RdDM)) != 1) begin
          errors++;
          $display("FAIL strobe_onehot: WrPM=%b WrDM=%b RdDM=%b", bus.WrPM, bus.WrDM, bus.RdDM);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: kind=%0d addr=%h data=%h, none expected",
                   k, bus.addrFromInterface, bus.dataFromInterface);
        end else begin
          automatic strobe_t e = exp_q.pop_front();
          if (k !== e.kind || bus.addrFromInterface !== e.addr ||
              (k != K_RD && bus.dataFromInterface !== e.data)) begin
            errors++;
            $display("FAIL strobe: got kind=%0d addr=%h data=%h, expected kind=%0d addr=%h data=%h",
                     k, bus.addrFromInterface, bus.dataFromInterface, e.kind, e.addr, e.data);
          end
        end
      end
      if (bus.tx_valid) begin
        checks++;
        if (tx_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tx: tx_data=%h, none expected", bus.tx_data);
        end else begin
          if (bus.tx_data !== tx_q[0]) begin
            errors++;
            $display("FAIL tx_byte: got %h expected %h", bus.tx_data, tx_q[0]);
          end
          if (bus.tx_ready) void'(tx_q.pop_front());
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    int n = 0;
    while (bus.busy && n < max_cycles) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (bus.busy) begin
      errors++;
      $display("FAIL %s_idle: busy still 1 after %0d cycles", name, max_cycles);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0 || tx_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d strobes and %0d tx bytes outstanding, expected 0",
               name, exp_q.size(), tx_q.size());
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    bus.rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if ({bus.WrPM, bus.WrDM, bus.RdDM, bus.tx_valid, bus.reset_bip, bus.busy, bus.cmd_err} !== 7'b0 ||
        bus.tx_data !== 8'h00 || bus.addrFromInterface !== 11'h000 || bus.dataFromInterface !== 16'h0000) begin
      errors++;
      $display("FAIL %s: strobes/txv/rbip/busy/err=%b tx=%h addr=%h data=%h, expected all 0",
               name, {bus.WrPM, bus.WrDM, bus.RdDM, bus.tx_valid, bus.reset_bip, bus.busy, bus.cmd_err},
               bus.tx_data, bus.addrFromInterface, bus.dataFromInterface);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    check_reset_values("reset_values");
    release_reset();
    check_reset_values("after_reset_release");
  endtask

  task automatic test_write_pm();
    exp_q.push_back('{K_PM, 11'h005, 16'h1234});
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h05); send_byte(8'h12); send_byte(8'h34);
    wait_idle("write_pm", 10);
    checks++;
    if (bus.addrFromInterface !== 11'h005 || bus.dataFromInterface !== 16'h1234) begin
      errors++;
      $display("FAIL write_pm_hold: addr=%h data=%h expected 005/1234",
               bus.addrFromInterface, bus.dataFromInterface);
    end
    check_bit("write_pm_no_err", bus.cmd_err, 1'b0);
    check_drained("write_pm");
  endtask

  task automatic test_write_dm();
    exp_q.push_back('{K_DM, 11'h7FF, 16'hABCD});
    send_byte(8'h02); send_byte(8'h07); send_byte(8'hFF); send_byte(8'hAB); send_byte(8'hCD);
    wait_idle("write_dm", 10);
    exp_q.push_back('{K_DM, 11'h700, 16'h0001});
    send_byte(8'h02); send_byte(8'hFF); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    wait_idle("write_dm_upper", 10);
    checks++;
    if (bus.addrFromInterface !== 11'h700) begin
      errors++;
      $display("FAIL write_dm_addr_trunc: addr=%h expected 700", bus.addrFromInterface);
    end
    check_drained("write_dm");
  endtask

  task automatic test_back_to_back();
    bus.tx_ready = 1'b1;
    exp_q.push_back('{K_DM, 11'h123, 16'hCAFE});
    send_byte(8'h02); send_byte(8'h01); send_byte(8'h23); send_byte(8'hCA); send_byte(8'hFE);
    wait_idle("b2b_write", 10);
    exp_q.push_back('{K_RD, 11'h123, 16'h0000});
    tx_q.push_back(8'hCA);
    tx_q.push_back(8'hFE);
    send_byte(8'h03); send_byte(8'h01); send_byte(8'h23);
    wait_idle("b2b_read", 20);
    check_bit("b2b_tx_valid_low", bus.tx_valid, 1'b0);
    check_drained("b2b");
  endtask

  task automatic test_read();
    int n = 0;
    bus.tx_ready = 1'b0;
    exp_q.push_back('{K_RD, 11'h010, 16'h0000});
    tx_q.push_back(8'hBE);
    tx_q.push_back(8'hEF);
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h10);
    while (!bus.tx_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_bit("read_tx_valid", bus.tx_valid, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    // Stray byte during the transfer: dropped, flagged, transfer keeps going
    send_byte(8'h55);
    check_bit("read_stray_err", bus.cmd_err, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    bus.tx_ready = 1'b1;
    wait_idle("read", 10);
    bus.tx_ready = 1'b0;
    check_bit("read_tx_valid_low", bus.tx_valid, 1'b0);
    check_drained("read");
  endtask

  task automatic test_run_halt();
    apply_reset();
    release_reset();
    send_byte(8'h04);
    check_bit("run_reset_bip", bus.reset_bip, 1'b1);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
    wait_idle("run_ignored", 10);
    check_bit("run_ignored_err", bus.cmd_err, 1'b1);
    send_byte(8'h05);
    check_bit("halt_reset_bip", bus.reset_bip, 1'b0);
    check_drained("run_halt");
  endtask

  task automatic test_timeout();
    int n = 0;
    apply_reset();
    release_reset();
    send_byte(8'h01); send_byte(8'h00);
    while (bus.busy && n < TO + 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != TO) begin
      errors++;
      $display("FAIL timeout_cycles: returned idle after %0d cycles, expected %0d", n, TO);
    end
    check_bit("timeout_err", bus.cmd_err, 1'b1);
    exp_q.push_back('{K_DM, 11'h003, 16'h0004});
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h03); send_byte(8'h00); send_byte(8'h04);
    wait_idle("after_timeout", 10);
    check_drained("timeout");
  endtask

  task automatic test_bad_opcode();
    apply_reset();
    release_reset();
    send_byte(8'h7F);
    check_bit("bad_opcode_err", bus.cmd_err, 1'b1);
    check_bit("bad_opcode_idle", bus.busy, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check_drained("bad_opcode");
  endtask

  task automatic test_reset_mid();
    send_byte(8'h04);
    check_bit("mid_run", bus.reset_bip, 1'b1);
    send_byte(8'h05);
    exp_q.push_back('{K_DM, 11'h2AA, 16'h5A5A});
    send_byte(8'h02); send_byte(8'h02); send_byte(8'hAA); send_byte(8'h5A); send_byte(8'h5A);
    wait_idle("mid_setup", 10);
    send_byte(8'h04);
    check_bit("mid_run_again", bus.reset_bip, 1'b1);
    send_byte(8'h05);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
    check_bit("mid_in_data_h", bus.busy, 1'b1);
    apply_reset();
    check_reset_values("mid_reset_values");
    release_reset();
    repeat (3) begin @(posedge clk); #1; end
    check_reset_values("mid_after_release");
    check_drained("reset_mid");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 2048; i++) dm_mem[i] = 16'h0000;
    dm_mem[11'h010] = 16'hBEEF;
    for (int i = 0; i < 8; i++) rd_addr_pipe[i] = 11'h000;
    @(posedge clk); #1;
    mon_en = 1'b1;
    test_reset();
    test_write_pm();
    test_write_dm();
    test_back_to_back();
    test_read();
    test_run_halt();
    test_timeout();
    test_bad_opcode();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
